// File: rtl/blink_loss_pkg.sv
// blink_loss_pkg: shared state encoding and default sizing
// for the Blink loss tracker.
package blink_loss_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENALTY = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int DEF_LIVES   = 3;
  localparam int DEF_PENALTY = 8;

endpackage

// File: rtl/blink_loss_if.sv
// blink_loss_if: game-side bundle between the Blink FSM and
// the loss tracker (stats ports when BLINK_LOSS_STATS_EN).
interface blink_loss_if #(
  parameter int CHANNELS = 4,
  parameter int LIFE_W   = 2
);
  logic                start;
  logic                clear;
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] q;
  logic                miss_pulse;
  logic [CHANNELS-1:0] miss_ch;
  logic [LIFE_W-1:0]   lives;
  logic                armed;
  logic                lose;
`ifdef BLINK_LOSS_STATS_EN
  logic [15:0]         miss_total;
  logic                ignored_pulse;

  modport master (
    output start, clear, sample, hit,
    input  q, miss_pulse, miss_ch, lives,
    input  armed, lose, miss_total, ignored_pulse
  );

  modport slave (
    input  start, clear, sample, hit,
    output q, miss_pulse, miss_ch, lives,
    output armed, lose, miss_total, ignored_pulse
  );
`else
  modport master (
    output start, clear, sample, hit,
    input  q, miss_pulse, miss_ch, lives,
    input  armed, lose
  );

  modport slave (
    input  start, clear, sample, hit,
    output q, miss_pulse, miss_ch, lives,
    output armed, lose
  );
`endif
endinterface

// File: rtl/blink_loss_chan.sv
// blink_loss_chan: one player channel, sampled hit register
// plus the combinational miss bit.
module blink_loss_chan (
  input  logic clk,
  input  logic reset,
  input  logic i_sample,
  input  logic i_hit,
  output logic o_q,
  output logic o_miss
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_q <= 1'b0;
    else if (i_sample)
      r_q <= i_hit;
  end

  assign o_q    = r_q;
  assign o_miss = i_sample & ~i_hit;

endmodule

// File: rtl/blink_loss_tracker.sv
// blink_loss_tracker: miss detection, lives and penalty window.
// Optional miss statistics under BLINK_LOSS_STATS_EN.
module blink_loss_tracker
  import blink_loss_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int LIVES          = DEF_LIVES,
  parameter int LIFE_W         = $clog2(LIVES + 1),
  parameter int PENALTY_CYCLES = DEF_PENALTY
) (
  input  logic        clk,
  input  logic        reset,
  blink_loss_if.slave bus
);

  localparam int PEN_W =
    (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  localparam logic [PEN_W-1:0] PEN_LOAD =
    PEN_W'((PENALTY_CYCLES > 0) ? PENALTY_CYCLES - 1 : 0);

  logic [CHANNELS-1:0] w_q;
  logic [CHANNELS-1:0] w_mv;
  logic                w_any;

  state_t              r_state;
  logic [LIFE_W-1:0]   r_lives;
  logic [PEN_W-1:0]    r_pen;
  logic                r_pulse;
  logic [CHANNELS-1:0] r_miss_ch;
  logic                r_armed;
  logic                r_lose;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    blink_loss_chan u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_sample (bus.sample[g]),
      .i_hit    (bus.hit[g]),
      .o_q      (w_q[g]),
      .o_miss   (w_mv[g])
    );
  end

  assign w_any = |w_mv;

  // clear beats start, start beats any miss in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lives   <= '0;
      r_pen     <= '0;
      r_pulse   <= 1'b0;
      r_miss_ch <= '0;
      r_armed   <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_miss_ch <= '0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_pen   <= '0;
        r_armed <= 1'b0;
        r_lose  <= 1'b0;
      end else if (bus.start) begin
        r_state <= ARMED;
        r_lives <= LIFE_W'(LIVES);
        r_pen   <= '0;
        r_armed <= 1'b1;
        r_lose  <= 1'b0;
      end else begin
        unique case (r_state)
          ARMED: begin
            if (w_any) begin
              r_pulse   <= 1'b1;
              r_miss_ch <= w_mv;
              r_lives   <= r_lives - 1'b1;
              if (r_lives == LIFE_W'(1)) begin
                r_state <= LOST;
                r_armed <= 1'b0;
                r_lose  <= 1'b1;
              end else if (PENALTY_CYCLES > 0) begin
                r_state <= PENALTY;
                r_pen   <= PEN_LOAD;
              end
            end
          end
          PENALTY: begin
            if (r_pen == '0)
              r_state <= ARMED;
            else
              r_pen <= r_pen - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.q          = w_q;
  assign bus.miss_pulse = r_pulse;
  assign bus.miss_ch    = r_miss_ch;
  assign bus.lives      = r_lives;
  assign bus.armed      = r_armed;
  assign bus.lose       = r_lose;

`ifdef BLINK_LOSS_STATS_EN
  logic [15:0] r_total;
  logic        r_ign;
  logic        w_live;

  assign w_live = (r_state == ARMED) || (r_state == PENALTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total <= '0;
      r_ign   <= 1'b0;
    end else begin
      r_ign <= 1'b0;
      if (bus.clear) begin
        r_total <= r_total;
      end else if (bus.start) begin
        r_total <= '0;
      end else if (w_any && w_live) begin
        if (r_total != 16'hFFFF)
          r_total <= r_total + 16'd1;
        r_ign <= (r_state == PENALTY);
      end
    end
  end

  assign bus.miss_total    = r_total;
  assign bus.ignored_pulse = r_ign;
`endif

endmodule
